// File: rtl/hack_register_bank_pkg.sv
// Shared Hack register-bank definitions: default word width, default bank
// depth and the address-width derivation macro used by the bank and its
// read ports.
`ifndef HACK_REGISTER_BANK_PKG_SV
`define HACK_REGISTER_BANK_PKG_SV

// Address width for a bank of d registers (d is a power of two, d >= 2).
`define HACK_REGBANK_ADDR_W(d) $clog2(d)

package hack_register_bank_pkg;

    localparam int unsigned HACK_WORD_W        = 16;
    localparam int unsigned HACK_REGBANK_DEPTH = 8;

endpackage

`endif

// File: rtl/hack_regbank_read_port.sv
// One registered read port of the Hack register bank.
// Selects a register and its valid bit by address and captures them on the
// rising edge when rd_en is high; otherwise the outputs hold their value.
// Optional feature macro HACK_REGBANK_BYPASS_EN: forward a same-cycle write
// to the same address, or a same-cycle clear, into the captured value.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_en, rd_addr      read enable and address
//   mem, mem_valid      storage array and valid bits from the bank
//   wr_en, wr_addr,
//   wr_data, clr        write/clear activity (bypass build only)
//   rd_data, rd_valid   registered read data and valid bit
import hack_register_bank_pkg::*;

module hack_regbank_read_port #(
    parameter  int unsigned WIDTH  = HACK_WORD_W,
    parameter  int unsigned DEPTH  = HACK_REGBANK_DEPTH,
    localparam int unsigned ADDR_W = `HACK_REGBANK_ADDR_W(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
    input  logic [DEPTH-1:0]             mem_valid,
`ifdef HACK_REGBANK_BYPASS_EN
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         clr,
`endif
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid
);

    logic [WIDTH-1:0] nxt_data;
    logic             nxt_valid;

    // Value to capture: stored contents, optionally overridden by same-cycle activity
    always_comb begin
        nxt_data  = mem[rd_addr];
        nxt_valid = mem_valid[rd_addr];
`ifdef HACK_REGBANK_BYPASS_EN
        // clr wins over a write, matching the storage update priority
        if (clr) begin
            nxt_data  = '0;
            nxt_valid = 1'b0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            nxt_data  = wr_data;
            nxt_valid = 1'b1;
        end
`endif
    end

    // Output register with enable-hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= nxt_data;
            rd_valid <= nxt_valid;
        end
    end

endmodule

// File: rtl/hack_register_bank.sv
// Hack register bank: DEPTH registers of WIDTH bits with one synchronous
// write port, two registered read ports (A, B), a synchronous clear-all and a
// per-register "written since clear" valid bit.
// Optional feature macro HACK_REGBANK_BYPASS_EN: read ports forward a
// same-cycle write or clear instead of returning the pre-edge contents.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data           write port
//   clr                               synchronous clear of data and valid bits
//   rd_en_a, rd_addr_a                read port A request
//   rd_data_a, rd_valid_a             read port A registered result
//   rd_en_b, rd_addr_b                read port B request
//   rd_data_b, rd_valid_b             read port B registered result
import hack_register_bank_pkg::*;

module hack_register_bank #(
    parameter  int unsigned WIDTH  = HACK_WORD_W,
    parameter  int unsigned DEPTH  = HACK_REGBANK_DEPTH,
    localparam int unsigned ADDR_W = `HACK_REGBANK_ADDR_W(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            valid;

    // Storage and valid bits; clr has priority over a write in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            valid <= '0;
        end else if (clr) begin
            mem   <= '0;
            valid <= '0;
        end else if (wr_en) begin
            mem[wr_addr]   <= wr_data;
            valid[wr_addr] <= 1'b1;
        end
    end

    hack_regbank_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_port_a (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en_a),
        .rd_addr   (rd_addr_a),
        .mem       (mem),
        .mem_valid (valid),
`ifdef HACK_REGBANK_BYPASS_EN
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr       (clr),
`endif
        .rd_data   (rd_data_a),
        .rd_valid  (rd_valid_a)
    );

    hack_regbank_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_port_b (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en_b),
        .rd_addr   (rd_addr_b),
        .mem       (mem),
        .mem_valid (valid),
`ifdef HACK_REGBANK_BYPASS_EN
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr       (clr),
`endif
        .rd_data   (rd_data_b),
        .rd_valid  (rd_valid_b)
    );

endmodule

// File: tb/tb_hack_register_bank.sv
// Directed self-checking bench for hack_register_bank (default 16 x 8).
module tb_hack_register_bank;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              clr;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid_b;

    int checks = 0;
    int errors = 0;

    hack_register_bank dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr        (clr),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)",
                   tag, obs, obs, exp, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
        rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;

        // Reset held for two cycles
        step(); step();
        check("rst_data_a",  rd_data_a, 16'd0);
        check("rst_data_b",  rd_data_b, 16'd0);
        check("rst_valid_a", 16'(rd_valid_a), 16'd0);
        check("rst_valid_b", 16'(rd_valid_b), 16'd0);

        rst = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        step();
        check("rd3_data_a",  rd_data_a, 16'd0);
        check("rd3_valid_a", 16'(rd_valid_a), 16'd0);
        rd_en_a = 1'b0;

        // Write then read on both ports
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h8285;   // -32123
        step();
        wr_addr = 3'd5; wr_data = 16'd12345;
        step();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 3'd2;
        rd_en_b = 1'b1; rd_addr_b = 3'd5;
        step();
        check("wr_rd_data_a",  rd_data_a, 16'h8285);
        check("wr_rd_data_b",  rd_data_b, 16'd12345);
        check("wr_rd_valid_a", 16'(rd_valid_a), 16'd1);
        check("wr_rd_valid_b", 16'(rd_valid_b), 16'd1);

        // Load enable low: data on the bus must not be stored
        wr_addr = 3'd2; wr_data = 16'd11111;
        step();
        step();
        check("no_wr_en_a", rd_data_a, 16'h8285);
        rd_en_a = 1'b0; rd_en_b = 1'b0;

        // Same-address read and write in one cycle
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd1;
        step();
        wr_data = 16'd0;
        rd_en_a = 1'b1; rd_addr_a = 3'd4;
        step();
`ifdef HACK_REGBANK_BYPASS_EN
        check("raw_same_cycle", rd_data_a, 16'd0);
`else
        check("raw_same_cycle", rd_data_a, 16'd1);
`endif
        wr_en = 1'b0;
        step();
        check("raw_next_cycle", rd_data_a, 16'd0);
        rd_en_a = 1'b0;

        // Clear priority over a simultaneous write
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 3'(i); wr_data = 16'(100 + i);
            step();
        end
        clr = 1'b1; wr_addr = 3'd1; wr_data = 16'd999;
        rd_en_a = 1'b1; rd_addr_a = 3'd1;
        rd_en_b = 1'b1; rd_addr_b = 3'd7;
        step();
`ifdef HACK_REGBANK_BYPASS_EN
        check("clr_cycle_a", rd_data_a, 16'd0);
        check("clr_cycle_b", rd_data_b, 16'd0);
        check("clr_cycle_valid_a", 16'(rd_valid_a), 16'd0);
`else
        check("clr_cycle_a", rd_data_a, 16'd101);
        check("clr_cycle_b", rd_data_b, 16'd107);
        check("clr_cycle_valid_a", 16'(rd_valid_a), 16'd1);
`endif
        clr = 1'b0; wr_en = 1'b0;
        step();
        check("clr_data_a",  rd_data_a, 16'd0);
        check("clr_data_b",  rd_data_b, 16'd0);
        check("clr_valid_a", 16'(rd_valid_a), 16'd0);
        check("clr_valid_b", 16'(rd_valid_b), 16'd0);
        rd_en_a = 1'b0; rd_en_b = 1'b0;

        // Read hold while a new value is written underneath
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'd12345;
        step();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 3'd5;
        step();
        check("hold_first", rd_data_a, 16'd12345);
        rd_en_a = 1'b0;
        wr_en = 1'b1; wr_data = 16'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_cycle%0d", i), rd_data_a, 16'd12345);
        end
        wr_en = 1'b0; rd_en_a = 1'b1;
        step();
        check("hold_release", rd_data_a, 16'd7);
        check("hold_release_valid", 16'(rd_valid_a), 16'd1);

        // Asynchronous reset between edges with a write pending
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'd555;
        #2;
        rst = 1'b1;
        #1;
        check("async_data_a",  rd_data_a, 16'd0);
        check("async_valid_a", 16'(rd_valid_a), 16'd0);
        rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            step();
            check($sformatf("post_rst_data%0d", i), rd_data_a, 16'd0);
            check($sformatf("post_rst_valid%0d", i), 16'(rd_valid_a), 16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_register_bank.md
Name: hack_register_bank

Overview:
- Parametrised successor of the single 16-bit load-enable Hack register: DEPTH registers of WIDTH bits each.
- One synchronous write port, two registered read ports (A, B), a synchronous clear-all command and a per-register "written since clear" valid bit.
- Serves as the CPU-side general register set and as the building block for RAM8-style memories in the Hack datapath.

Parameters:
- WIDTH, 16, data width of each register in bits; data is treated as raw bits, signed by convention.
- DEPTH, 8, number of registers; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write enable; when high, wr_data is stored at wr_addr on the edge.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- clr  input  1  synchronous clear of all registers and valid bits.
- rd_en_a  input  1  read enable, port A.
- rd_addr_a  input  ADDR_W  read address, port A.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_valid_a  output  1  valid bit of the register read on port A.
- rd_en_b  input  1  read enable, port B.
- rd_addr_b  input  ADDR_W  read address, port B.
- rd_data_b  output  WIDTH  registered read data, port B.
- rd_valid_b  output  1  valid bit of the register read on port B.

Behaviour:
- Reset (rst=1, asynchronous, independent of clk):
  - all registers = 0 and all valid bits = 0;
  - rd_data_a = rd_data_b = 0 and rd_valid_a = rd_valid_b = 0;
  - the block holds this state while rst is high.
- Write: on a rising edge with wr_en=1 and clr=0, reg[wr_addr] <= wr_data and valid[wr_addr] <= 1. wr_en=0 leaves all registers unchanged (load-enable semantics, as for the single register).
- Clear: on a rising edge with clr=1, all registers <= 0 and all valid bits <= 0. clr has priority over wr_en in the same cycle; that write is dropped.
- Read, 1-cycle latency:
  - on a rising edge with rd_en_x=1, rd_data_x <= reg[rd_addr_x] and rd_valid_x <= valid[rd_addr_x], both taken from their pre-edge values;
  - with rd_en_x=0, rd_data_x and rd_valid_x hold their previous values.
- Both read ports are independent. Both may read the same address in the same cycle; both return the same value.
- Read and write to the same address in the same cycle, without the optional feature: the read returns the old contents; the new value is visible one cycle later.
- Read during clr, without the optional feature: the read returns the pre-clear contents and valid bit.
- No arithmetic is performed. Addresses cover exactly 0..DEPTH-1, so there is no out-of-range case.
- rst asserted mid-operation: the async clear overrides any write, clear or read in flight. The first edge after rst deasserts behaves normally.

Optional Feature:
- Macro: HACK_REGBANK_BYPASS_EN.
- Defined: read ports forward same-cycle state changes.
  - rd_en_x=1, wr_en=1, clr=0, rd_addr_x==wr_addr: rd_data_x <= wr_data and rd_valid_x <= 1.
  - rd_en_x=1, clr=1: rd_data_x <= 0 and rd_valid_x <= 0.
- Undefined: no forwarding; the old-value read behaviour above applies.
- Write and clear behaviour are identical in both builds.

Decomposition:
- Shared package/header (alongside the existing Hack macros):
  - HACK_WORD_W = 16 and the default DEPTH of 8;
  - a macro for the ADDR_W derivation.
- One sub-module: hack_regbank_read_port. It holds the registered output, the enable-hold logic and the optional bypass mux, and is instantiated twice (A and B).
- Storage array and valid bits stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> rd_data_a = rd_data_b = 0 and rd_valid_a = rd_valid_b = 0. Then read address 3 -> rd_data_a = 0, rd_valid_a = 0.
- Write then read: write -32123 to addr 2 and 12345 to addr 5; next cycle read A=2, B=5 -> rd_data_a = -32123, rd_data_b = 12345, both valid = 1. wr_en=0 with wr_data=11111 at addr 2 -> addr 2 still reads -32123.
- Same-address read/write: reg[4]=1; in one cycle write 0 to addr 4 and read A=4.
  - No macro: rd_data_a = 1, then 0 on the following read.
  - HACK_REGBANK_BYPASS_EN defined: rd_data_a = 0 immediately.
- Clear priority: regs 0..7 hold 100..107; assert clr together with a write of 999 to addr 1 -> next-cycle reads of addr 1 and addr 7 return 0 with valid = 0; the value 999 is never observed.
- Read hold: read addr 5 (12345), then drop rd_en_a for 3 cycles while writing addr 5 = 7 -> rd_data_a stays 12345 until rd_en_a is raised again, then reads 7.
- Async reset mid-operation: pulse rst between clock edges while a write is pending -> outputs go to 0 immediately, without waiting for an edge, and all registers read back 0, valid = 0.
